acq_sequencer: RTL
==================

Name: acq_sequencer

Overview:
- Per-acquisition controller for the lidar ADQ214 capture/accumulate datapath.
- Takes the latched user-register fields (total points, range bins, points per bin, accumulated pulses, command word) and sequences the work:
  - arm on a start command
  - open a sample window on each laser trigger
  - strobe range-bin boundaries
  - count accumulated pulses
  - signal completion
- Drives the update-disable input of the SPI command latch so that parameters are frozen during an acquisition.

Parameters:
- W, 16, width of all count/parameter fields.
- TIMEOUT_CYCLES, 32'd125000000, ARM-state trigger timeout in clk cycles. Used only with TRIG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- ur_cmd  in  W  command word. Bit0 = start (rising edge acts). Bit1 = abort (level). Other bits ignored.
- ur_ntotal_points  in  W  samples per trigger window.
- ur_nrange_bins  in  W  number of range bins reported.
- ur_npoints_rb  in  W  samples per range bin.
- ur_nacc_pulses  in  W  pulses to accumulate.
- trig_i  in  1  trigger level from the comparator; rising edge is the event.
- cmd_update_disable  out  1  high whenever state is not IDLE.
- busy  out  1  equal to cmd_update_disable.
- sample_en  out  1  high for each sample cycle inside the window.
- acc_first  out  1  high with sample_en during pulse 0. The accumulator uses it to load instead of add.
- rb_strobe  out  1  one-cycle pulse on the last sample of each reported bin.
- rb_index  out  W  current bin index, valid while sample_en=1.
- pulse_index  out  W  pulses completed in this acquisition.
- acc_done  out  1  one-cycle completion pulse.
- param_err  out  1  one-cycle pulse when a start is rejected.
- missed_trig  out  W  saturating count of triggers ignored while in CAPTURE. Cleared on accepted start.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE
  - all outputs 0
  - trig_d=0, start_d=0
- Edge detection:
  - trig_d and start_d are registered copies.
  - trig_rise = trig_i & ~trig_d.
  - start_rise = ur_cmd[0] & ~start_d.
- All outputs are registered. Decisions use values sampled at the current edge.
- IDLE:
  - On start_rise, check parameters. Valid means ntotal_points≠0, npoints_rb≠0, nacc_pulses≠0, and nrange_bins*npoints_rb ≤ ntotal_points (product computed at 2W bits).
  - Valid: go to ARM; clear pulse_index and missed_trig.
  - Invalid: pulse param_err; stay in IDLE.
- ARM:
  - On trig_rise, go to CAPTURE.
  - sample_en is 1 from the edge after trig_rise is sampled, for exactly ntotal_points cycles.
- CAPTURE:
  - sample counter s counts 0..ntotal_points-1. sample_en=1 throughout.
  - Bin counter b counts 0..npoints_rb-1, wrapping.
  - rb_strobe=1 when b=npoints_rb-1 and rb_index<nrange_bins.
  - rb_index increments after each wrap and saturates at nrange_bins.
  - Samples beyond the last bin still assert sample_en, with rb_strobe=0.
  - acc_first = sample_en & (pulse_index==0).
  - A trig_rise here is ignored and increments missed_trig, saturating at all-ones.
  - Leaving CAPTURE on the last sample:
    - pulse_index increments.
    - If the new value equals nacc_pulses, go to DONE; otherwise go to ARM.
    - A trig_rise on that same edge is counted as missed, not re-armed.
- DONE:
  - acc_done=1 for one cycle, then IDLE.
  - cmd_update_disable drops on the cycle after acc_done.
- Parameters are sampled into internal copies on the accepted start edge. Input changes mid-acquisition have no effect.
- Abort (ur_cmd[1]=1, from any non-IDLE state): next state is IDLE.
  - sample_en, rb_strobe and acc_first are 0 on the following cycle.
  - No acc_done.
  - pulse_index holds its value.
- Abort has priority over every other transition.
- In IDLE, start_rise is ignored while ur_cmd[1]=1.
- A start_rise outside IDLE is ignored.
- rst_n=0 mid-acquisition returns to the full reset state on that edge.
- Counter arithmetic is W bits, unsigned. Comparisons are equality only; no wrap-around occurs.

Optional Feature:
- Macro: TRIG_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in ARM and is cleared on entry to ARM.
  - When it reaches TIMEOUT_CYCLES-1 without trig_rise, the block goes to IDLE.
  - Adds output timeout_err, a one-cycle pulse. No acc_done is issued.
  - If trig_rise falls on the expiry cycle, the trigger wins.
- Undefined: ARM waits indefinitely, and the timeout_err port does not exist.

Test Plan:
- Basic acquisition:
  - Stimulus: ntotal=8, npoints_rb=2, nbins=3, nacc=2; start, then 2 triggers 20 cycles apart.
  - Response: 2 windows of 8 sample_en cycles; rb_strobe on samples 1, 3, 5 of each window; acc_first only in window 0; acc_done once; pulse_index=2.
- Parameter rejection:
  - Stimulus: nbins=5, npoints_rb=2, ntotal=8, then start.
  - Response: param_err pulse; busy stays 0. Also repeat with nacc=0 and require param_err.
- Missed trigger:
  - Stimulus: ntotal=10; second trig_rise 4 cycles into the window.
  - Response: window still 10 samples; missed_trig=1; pulse not counted.
- Abort:
  - Stimulus: ur_cmd[1]=1 at sample 3 of pulse 1.
  - Response: sample_en=0 next cycle; IDLE; no acc_done; cmd_update_disable=0.
- Reset and parameter freeze:
  - Stimulus: rst_n=0 during CAPTURE; separately, change ntotal mid-acquisition.
  - Response: all outputs 0 after the reset edge; window length unchanged by the new ntotal.
- TRIG_TIMEOUT_EN:
  - Stimulus: TIMEOUT_CYCLES=50; start with no trigger.
  - Response: timeout_err at cycle 50 of ARM, then IDLE.

Source files
------------

// File: rtl/acq_sequencer_if.sv
// Parameter, trigger and sequencing signals of acq_sequencer; the DUT side uses the slave modport.
// Macro TRIG_TIMEOUT_EN adds the timeout_err member.
interface acq_sequencer_if #(
    parameter int W = 16
);
    logic [W-1:0] ur_cmd;
    logic [W-1:0] ur_ntotal_points;
    logic [W-1:0] ur_nrange_bins;
    logic [W-1:0] ur_npoints_rb;
    logic [W-1:0] ur_nacc_pulses;
    logic         trig_i;
    logic         cmd_update_disable;
    logic         busy;
    logic         sample_en;
    logic         acc_first;
    logic         rb_strobe;
    logic [W-1:0] rb_index;
    logic [W-1:0] pulse_index;
    logic         acc_done;
    logic         param_err;
    logic [W-1:0] missed_trig;
`ifdef TRIG_TIMEOUT_EN
    logic         timeout_err;

    modport master (
        output ur_cmd, ur_ntotal_points, ur_nrange_bins, ur_npoints_rb, ur_nacc_pulses, trig_i,
        input  cmd_update_disable, busy, sample_en, acc_first, rb_strobe, rb_index,
               pulse_index, acc_done, param_err, missed_trig, timeout_err
    );
    modport slave (
        input  ur_cmd, ur_ntotal_points, ur_nrange_bins, ur_npoints_rb, ur_nacc_pulses, trig_i,
        output cmd_update_disable, busy, sample_en, acc_first, rb_strobe, rb_index,
               pulse_index, acc_done, param_err, missed_trig, timeout_err
    );
`else
    modport master (
        output ur_cmd, ur_ntotal_points, ur_nrange_bins, ur_npoints_rb, ur_nacc_pulses, trig_i,
        input  cmd_update_disable, busy, sample_en, acc_first, rb_strobe, rb_index,
               pulse_index, acc_done, param_err, missed_trig
    );
    modport slave (
        input  ur_cmd, ur_ntotal_points, ur_nrange_bins, ur_npoints_rb, ur_nacc_pulses, trig_i,
        output cmd_update_disable, busy, sample_en, acc_first, rb_strobe, rb_index,
               pulse_index, acc_done, param_err, missed_trig
    );
`endif
endinterface

// File: rtl/acq_sequencer.sv
// Per-acquisition sequencer: arm, capture trigger windows, strobe range bins, count pulses.
// Macro TRIG_TIMEOUT_EN enables the ARM-state trigger timeout and timeout_err.
module acq_sequencer #(
    parameter int          W              = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd125000000
) (
    input  logic           clk,
    input  logic           rst_n,
    acq_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_q, state_d;
    logic         trig_dly_q, start_dly_q;
    logic [W-1:0] ntot_q, ntot_d, nprb_q, nprb_d, nbins_q, nbins_d, nacc_q, nacc_d;
    logic [W-1:0] smp_q, smp_d, bin_q, bin_d, rb_q, rb_d;
    logic [W-1:0] pulse_q, pulse_d, missed_q, missed_d;
    logic         sample_en_q, sample_en_d, acc_first_q, acc_first_d;
    logic         rb_strobe_q, rb_strobe_d, acc_done_q, acc_done_d;
    logic         param_err_q, param_err_d, busy_q, busy_d;
    logic         trig_rise, start_rise, abort, params_ok, bin_wrap;
    logic [W-1:0] pulse_inc;
    logic [2*W-1:0] bin_span;
    logic         unused_cmd_bits;
`ifdef TRIG_TIMEOUT_EN
    logic [31:0]  tmo_q, tmo_d;
    logic         timeout_err_q, timeout_err_d;
`else
    localparam logic [31:0] unused_timeout = TIMEOUT_CYCLES;
`endif

    assign trig_rise       = bus.trig_i & ~trig_dly_q;
    assign start_rise      = bus.ur_cmd[0] & ~start_dly_q;
    assign abort           = bus.ur_cmd[1];
    assign unused_cmd_bits = ^bus.ur_cmd[W-1:2];
    assign pulse_inc       = pulse_q + ONE;
    assign bin_wrap        = (bin_q == nprb_q - ONE);

    // Bins must fit in the window; the product is formed at double width so it cannot wrap.
    assign bin_span  = (2*W)'(bus.ur_nrange_bins) * (2*W)'(bus.ur_npoints_rb);
    assign params_ok = (bus.ur_ntotal_points != '0) && (bus.ur_npoints_rb != '0) &&
                       (bus.ur_nacc_pulses != '0) &&
                       (bin_span <= {{W{1'b0}}, bus.ur_ntotal_points});

    always_comb begin
        state_d     = state_q;
        ntot_d      = ntot_q;
        nprb_d      = nprb_q;
        nbins_d     = nbins_q;
        nacc_d      = nacc_q;
        smp_d       = '0;
        bin_d       = '0;
        rb_d        = '0;
        pulse_d     = pulse_q;
        missed_d    = missed_q;
        sample_en_d = 1'b0;
        acc_first_d = 1'b0;
        rb_strobe_d = 1'b0;
        acc_done_d  = 1'b0;
        param_err_d = 1'b0;
`ifdef TRIG_TIMEOUT_EN
        tmo_d         = tmo_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_rise && !abort) begin
                    if (params_ok) begin
                        state_d  = ARM;
                        ntot_d   = bus.ur_ntotal_points;
                        nprb_d   = bus.ur_npoints_rb;
                        nbins_d  = bus.ur_nrange_bins;
                        nacc_d   = bus.ur_nacc_pulses;
                        pulse_d  = '0;
                        missed_d = '0;
`ifdef TRIG_TIMEOUT_EN
                        tmo_d    = '0;
`endif
                    end else begin
                        param_err_d = 1'b1;
                    end
                end
            end
            ARM: begin
                if (trig_rise) begin
                    state_d     = CAPTURE;
                    sample_en_d = 1'b1;
                    acc_first_d = (pulse_q == '0);
                    rb_strobe_d = (nprb_q == ONE) && (nbins_q != '0);
                end
`ifdef TRIG_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            CAPTURE: begin
                if (trig_rise && (missed_q != '1)) begin
                    missed_d = missed_q + ONE;
                end
                if (smp_q == ntot_q - ONE) begin
                    pulse_d    = pulse_inc;
                    acc_done_d = (pulse_inc == nacc_q);
                    state_d    = (pulse_inc == nacc_q) ? DONE : ARM;
`ifdef TRIG_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end else begin
                    // Registered outputs describe the sample shown next cycle.
                    smp_d       = smp_q + ONE;
                    bin_d       = bin_wrap ? '0 : bin_q + ONE;
                    rb_d        = (bin_wrap && (rb_q < nbins_q)) ? rb_q + ONE : rb_q;
                    sample_en_d = 1'b1;
                    acc_first_d = (pulse_q == '0);
                    rb_strobe_d = (bin_d == nprb_q - ONE) && (rb_d < nbins_q);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && abort) begin
            state_d     = IDLE;
            smp_d       = '0;
            bin_d       = '0;
            rb_d        = '0;
            pulse_d     = pulse_q;
            missed_d    = missed_q;
            sample_en_d = 1'b0;
            acc_first_d = 1'b0;
            rb_strobe_d = 1'b0;
            acc_done_d  = 1'b0;
`ifdef TRIG_TIMEOUT_EN
            timeout_err_d = 1'b0;
`endif
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            trig_dly_q  <= 1'b0;
            start_dly_q <= 1'b0;
            ntot_q      <= '0;
            nprb_q      <= '0;
            nbins_q     <= '0;
            nacc_q      <= '0;
            smp_q       <= '0;
            bin_q       <= '0;
            rb_q        <= '0;
            pulse_q     <= '0;
            missed_q    <= '0;
            sample_en_q <= 1'b0;
            acc_first_q <= 1'b0;
            rb_strobe_q <= 1'b0;
            acc_done_q  <= 1'b0;
            param_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_dly_q  <= bus.trig_i;
            start_dly_q <= bus.ur_cmd[0];
            ntot_q      <= ntot_d;
            nprb_q      <= nprb_d;
            nbins_q     <= nbins_d;
            nacc_q      <= nacc_d;
            smp_q       <= smp_d;
            bin_q       <= bin_d;
            rb_q        <= rb_d;
            pulse_q     <= pulse_d;
            missed_q    <= missed_d;
            sample_en_q <= sample_en_d;
            acc_first_q <= acc_first_d;
            rb_strobe_q <= rb_strobe_d;
            acc_done_q  <= acc_done_d;
            param_err_q <= param_err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef TRIG_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`endif

    assign bus.cmd_update_disable = busy_q;
    assign bus.busy               = busy_q;
    assign bus.sample_en          = sample_en_q;
    assign bus.acc_first          = acc_first_q;
    assign bus.rb_strobe          = rb_strobe_q;
    assign bus.rb_index           = rb_q;
    assign bus.pulse_index        = pulse_q;
    assign bus.acc_done           = acc_done_q;
    assign bus.param_err          = param_err_q;
    assign bus.missed_trig        = missed_q;
endmodule
